// File: rtl/dotp_accum.sv
// dotp_accum: signed dot-product accumulator for vectors that span one or more beats.
// LANES products are formed in S1, reduced in S2 and accumulated in S3. On a last
// beat the accumulator is scaled, optionally rounded and saturated, and queued in a
// first-word-fall-through output FIFO that has stop/push flow control.
module dotp_accum #(
   parameter int unsigned LANES  = 20,
   parameter int unsigned DW     = 32,
   parameter int unsigned ACCW   = 72,
   parameter int unsigned SHIFT  = 35,
   parameter int unsigned OW     = 32,
   parameter int unsigned RND    = 0,
   parameter int unsigned SAT    = 0,
   parameter int unsigned FDEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pushin,
   input  logic                firstin,
   input  logic                lastin,
   input  logic [LANES*DW-1:0] din,
   input  logic [LANES*DW-1:0] win,
   output logic                stopin,
   input  logic                stopout,
   output logic                pushout,
   output logic [OW-1:0]       res
);

   localparam int unsigned PW   = 2 * DW;
   localparam int unsigned AW   = $clog2(FDEPTH);
   // FIFO count spans 0..FDEPTH.
   localparam int unsigned CW   = AW + 1;
   // Count plus up to three in-flight results stays below 2*FDEPTH.
   localparam int unsigned OCCW = CW + 1;

   // Rounding constant and saturation bounds, one bit wider than the accumulator.
   localparam logic signed [ACCW:0] RndC =
      (RND != 0) ? ((ACCW + 1)'(1) << (SHIFT - 1)) : '0;
   localparam logic signed [ACCW:0] SatMax = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic signed [ACCW:0] SatMin = ~SatMax;

   // ---------------------------------------------------------------------------------
   // S1: lane multipliers
   // ---------------------------------------------------------------------------------
   logic                 accept;
   logic signed [PW-1:0] prod_d [LANES];
   logic signed [PW-1:0] prod_q [LANES];
   logic                 v1_q;
   logic                 f1_q;
   logic                 l1_q;

   // A beat offered while stopin is high is dropped entirely.
   assign accept = pushin & ~stopin;

   // Sign-extend each element to PW first so every product is exact.
   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         prod_d[i] = PW'($signed(din[i*DW +: DW])) * PW'($signed(win[i*DW +: DW]));
      end
   end

   // S1 control flags; only accepted beats become valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         f1_q <= 1'b0;
         l1_q <= 1'b0;
      end else begin
         v1_q <= accept;
         f1_q <= firstin;
         l1_q <= lastin;
      end
   end

   // S1 product registers load only on an accepted beat.
   always_ff @(posedge clk) begin
      if (accept) begin
         prod_q <= prod_d;
      end
   end

   // ---------------------------------------------------------------------------------
   // S2: reduction
   // ---------------------------------------------------------------------------------
   logic signed [ACCW-1:0] sum_d;
   logic signed [ACCW-1:0] sum2_q;
   logic                   v2_q;
   logic                   f2_q;
   logic                   l2_q;

   // Adder tree over the sign-extended products.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         sum_d = sum_d + ACCW'(prod_q[i]);
      end
   end

   // S2 registers: reduced sum plus the flags of the same beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         v2_q <= 1'b0;
         f2_q <= 1'b0;
         l2_q <= 1'b0;
      end else begin
         v2_q <= v1_q;
         f2_q <= f1_q;
         l2_q <= l1_q;
         if (v1_q) begin
            sum2_q <= sum_d;
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // S3: accumulate, scale, round, saturate
   // ---------------------------------------------------------------------------------
   logic signed [ACCW-1:0] acc_q;
   logic signed [ACCW-1:0] acc_base;
   logic signed [ACCW-1:0] acc_new;
   logic                   idle_q;
   logic signed [ACCW:0]   acc_rnd;
   logic signed [ACCW:0]   acc_shr;
   logic [OW-1:0]          r_sat;
   logic [OW-1:0]          r3_d;
   logic [OW-1:0]          r3_q;
   logic                   v3_q;

   // First beat, or any beat while idle, starts a fresh vector; the extra top bit keeps
   // the rounding add from wrapping.
   always_comb begin
      acc_base = (f2_q || idle_q) ? '0 : acc_q;
      acc_new  = acc_base + sum2_q;
      acc_rnd  = {acc_new[ACCW-1], acc_new} + RndC;
      acc_shr  = acc_rnd >>> SHIFT;
      if (acc_shr > SatMax) begin
         r_sat = SatMax[OW-1:0];
      end else if (acc_shr < SatMin) begin
         r_sat = SatMin[OW-1:0];
      end else begin
         r_sat = acc_shr[OW-1:0];
      end
      r3_d = (SAT != 0) ? r_sat : acc_shr[OW-1:0];
   end

   // Accumulator and result register; a last beat returns the accumulator to idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         idle_q <= 1'b1;
         v3_q   <= 1'b0;
         r3_q   <= '0;
      end else begin
         v3_q <= v2_q & l2_q;
         if (v2_q) begin
            acc_q  <= acc_new;
            idle_q <= l2_q;
         end
         if (v2_q && l2_q) begin
            r3_q <= r3_d;
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // Output FIFO (first-word-fall-through)
   // ---------------------------------------------------------------------------------
   logic [OW-1:0]   mem_q [FDEPTH];
   logic [AW-1:0]   wptr_q;
   logic [AW-1:0]   rptr_q;
   logic [CW-1:0]   cnt_q;
   logic [OCCW-1:0] occ;
   logic            fifo_pop;

   // Outputs come from registered state and stopout only. Counting in-flight results
   // against the depth means an accepted last beat always finds a free slot.
   always_comb begin
      fifo_pop = (cnt_q != '0) && !stopout;
      pushout  = fifo_pop;
      res      = fifo_pop ? mem_q[rptr_q] : '0;
      occ      = OCCW'(cnt_q) + OCCW'(v1_q & l1_q) + OCCW'(v2_q & l2_q) + OCCW'(v3_q);
      stopin   = occ >= OCCW'(FDEPTH);
   end

   // FIFO pointers and count; simultaneous write and pop keep the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (v3_q) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (fifo_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         case ({v3_q, fifo_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      if (v3_q) begin
         mem_q[wptr_q] <= r3_q;
      end
   end

endmodule
